fifo_push_gen: RTL
==================

FIFO_PUSH_GEN -- requirements
Module: fifo_push_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the pushed word.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of the burst-length field.
REQ-003 SHALL have port wr_clk  input  1  write-domain clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle burst request.
REQ-006 SHALL have port len_i  input  LEN_WIDTH  number of words to push; sampled with start_i.
REQ-007 SHALL have port seed_i  input  DATA_WIDTH  first pattern value; sampled with start_i.
REQ-008 SHALL have port full_i  input  1  FIFO write-side full flag.
REQ-009 SHALL have port wr_en_o  output  1  FIFO write enable.
REQ-010 SHALL have port wr_data_o  output  DATA_WIDTH  FIFO write data.
REQ-011 SHALL have port busy_o  output  1  burst in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle burst-complete pulse.
REQ-013 SHALL have port count_o  output  16  total accepted pushes since reset.

Function
REQ-014 SHALL implement FSM states IDLE, PUSH, DONE.
REQ-015 IDLE: start_i=1 with len_i!=0 SHALL load remaining=len_i and data=seed_i, then go to PUSH.
REQ-016 IDLE: start_i=1 with len_i==0 SHALL go to DONE with no push.
REQ-017 wr_en_o SHALL be combinational: (state==PUSH) & ~full_i; never asserted while full_i=1.
REQ-018 A push is accepted on every rising edge where wr_en_o=1; wr_data_o SHALL equal the data register in that cycle.
REQ-019 On each accepted push: remaining decrements, data advances to the next pattern value, count_o increments (wraps at 2^16).
REQ-020 Accepted push with remaining==1 SHALL go to DONE; done_o=1 for exactly that DONE cycle, then IDLE.
REQ-021 full_i=1 in PUSH SHALL stall: no state, data, remaining or count change.
REQ-022 With full_i=0 throughout, a burst of N SHALL push on N consecutive cycles, the first in the cycle after start_i; done_o SHALL rise in cycle N+1 after start_i.
REQ-023 busy_o SHALL be 1 in PUSH and DONE, 0 in IDLE.
REQ-024 start_i SHALL be ignored outside IDLE.
REQ-025 Incrementing pattern: next = data+1 modulo 2^DATA_WIDTH (wraps 0xFF->0x00 at width 8).

Reset
REQ-026 rst_n=1 SHALL force IDLE immediately, regardless of clock.
REQ-027 In reset: wr_en_o=0, wr_data_o=0, busy_o=0, done_o=0, count_o=0, remaining=0.
REQ-028 Reset asserted mid-burst SHALL abort it; no further pushes and no done_o pulse for that burst.

Configuration
REQ-029 Macro FIFO_PUSH_GEN_LFSR_EN defined: pattern SHALL be a Galois LFSR, right-shift, XOR mask 0xB8 at DATA_WIDTH=8 (x^8+x^6+x^5+x^4+1); a zero seed SHALL load as 1.
REQ-030 Macro undefined: pattern SHALL be the incrementing sequence of REQ-025; seed used unmodified, zero permitted.

Structure
REQ-031 Shared package fifo_push_gen_pkg SHALL hold the state enum (IDLE/PUSH/DONE), the count width constant (16) and the LFSR mask constant.
REQ-032 Pattern advance SHALL be one sub-module, push_pattern_next (current value in, next value out), selected by FIFO_PUSH_GEN_LFSR_EN.

Verification
REQ-033 Macro off, full_i=0, start len=4 seed=0x10 -> pushes 0x10,0x11,0x12,0x13 on 4 consecutive cycles; done_o pulse 5 cycles after start; count_o=4.
REQ-034 Macro off, len=3 seed=0xFE -> pushes 0xFE,0xFF,0x00.
REQ-035 len=4, full_i=1 for 3 cycles after the second push -> wr_en_o=0 during stall; 4 pushes total, no duplicate or skipped value.
REQ-036 len=0 -> no wr_en_o; done_o one cycle after start; count_o unchanged.
REQ-037 rst_n pulsed after 2 of 8 pushes -> wr_en_o drops immediately, count_o=0, no done_o; a new start len=2 then completes normally.
REQ-038 Macro on, len=3 seed=0x00 -> pushes 0x01,0xB8,0x5C.

Source files
------------

// File: rtl/fifo_push_gen_pkg.sv
// Shared definitions for the FIFO push generator.
//   state_e   : burst FSM states (IDLE / PUSH / DONE)
//   COUNT_W   : width of the accepted-push counter
//   LFSR_MASK : Galois XOR mask for the optional LFSR pattern
//               (x^8+x^6+x^5+x^4+1, right-shift form)
package fifo_push_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned COUNT_W   = 16;
  localparam logic [7:0]  LFSR_MASK = 8'hB8;

endpackage

// File: rtl/fifo_push_gen_pattern.sv
// push_pattern_next: combinational pattern advance for fifo_push_gen.
//   cur_i  : current pattern value
//   next_o : next pattern value
// Build option FIFO_PUSH_GEN_LFSR_EN selects a right-shift Galois LFSR;
// otherwise the pattern is a wrapping increment.
module push_pattern_next
  import fifo_push_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] cur_i,
  output logic [DATA_WIDTH-1:0] next_o
);

`ifdef FIFO_PUSH_GEN_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] MASK = DATA_WIDTH'(LFSR_MASK);

  always_comb begin
    next_o = (cur_i >> 1) ^ (cur_i[0] ? MASK : '0);
  end
`else
  always_comb begin
    next_o = cur_i + DATA_WIDTH'(1);
  end
`endif

endmodule

// File: rtl/fifo_push_gen.sv
// fifo_push_gen: pushes a burst of pattern words into a FIFO write port.
//   wr_clk    : write-domain clock
//   rst_n     : asynchronous reset, active-high (legacy name)
//   start_i   : one-cycle burst request (ignored unless idle)
//   len_i     : burst length, sampled with start_i (0 = empty burst)
//   seed_i    : first pattern value, sampled with start_i
//   full_i    : FIFO full; stalls the burst
//   wr_en_o   : FIFO write enable (combinational, never while full)
//   wr_data_o : FIFO write data
//   busy_o    : burst in progress (PUSH or DONE)
//   done_o    : one-cycle burst-complete pulse
//   count_o   : total accepted pushes since reset (wraps)
// Build option FIFO_PUSH_GEN_LFSR_EN: LFSR pattern, zero seed loads as 1.
module fifo_push_gen
  import fifo_push_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  full_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [COUNT_W-1:0]    count_o
);

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] seed_d;
  logic [COUNT_W-1:0]    count_q;

  push_pattern_next #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .cur_i (data_q),
    .next_o(data_d)
  );

`ifdef FIFO_PUSH_GEN_LFSR_EN
  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  always_comb begin
    seed_d = (seed_i == '0) ? DATA_WIDTH'(1) : seed_i;
  end
`else
  always_comb begin
    seed_d = seed_i;
  end
`endif

  always_comb begin
    wr_en_o   = (state_q == PUSH) & ~full_i;
    wr_data_o = data_q;
    busy_o    = (state_q != IDLE);
    done_o    = (state_q == DONE);
    count_o   = count_q;
  end

  always_ff @(posedge wr_clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              rem_q   <= len_i;
              data_q  <= seed_d;
              state_q <= PUSH;
            end else begin
              state_q <= DONE;
            end
          end
        end
        PUSH: begin
          // full_i freezes all burst state; only accepted pushes advance it.
          if (!full_i) begin
            rem_q   <= rem_q - LEN_WIDTH'(1);
            data_q  <= data_d;
            count_q <= count_q + COUNT_W'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
